binoc_channel_ctrl: RTL and testbench

Direction controller for one end of a bidirectional inter-router link in the BiNoC mesh. One instance sits beside each Baserouter port that shares a physical channel with a neighbour; the two instances at opposite ends of a link negotiate channel ownership through a request/acknowledge pair. The instance that owns the link grants flits from the local output side. The controller locks the link for the duration of a packet, which keeps wormhole packets intact. It also bounds owner tenure to prevent starvation.

---
 rtl/binoc_channel_ctrl.sv | 124 ++++++++++++
 tb/tb_binoc_channel_ctrl.sv | 207 ++++++++++++++++++++
 2 files changed

// File: rtl/binoc_channel_ctrl.sv
// Direction controller for one end of a bidirectional BiNoC link.
// Negotiates link ownership with the opposite end through a request/ack pair,
// locks the link for whole packets and bounds owner tenure while the remote
// end is waiting.
module binoc_channel_ctrl #(
    parameter int unsigned INIT_OWNER  = 1,
    parameter int unsigned MAX_PKTS    = 4,
    parameter int unsigned TURN_CYCLES = 1
) (
    input  logic clk,
    input  logic rst,
    input  logic localReq,
    input  logic localTail,
    input  logic dnStrFull,
    output logic localGnt,
    output logic chReqOut,
    input  logic chReqIn,
    output logic chAckOut,
    input  logic chAckIn,
    output logic dirOut,
    output logic pktActive
);

    typedef enum logic [2:0] {
        OWN_IDLE,
        OWN_XFER,
        RELEASE,
        NOT_OWN,
        REQ,
        TURN
    } state_t;

    localparam state_t     RST_STATE = (INIT_OWNER != 0) ? OWN_IDLE : NOT_OWN;
    localparam logic       RST_DIR   = (INIT_OWNER != 0);
    localparam logic [3:0] MAX_CNT   = 4'(MAX_PKTS);
    localparam logic [2:0] TURN_LD   = 3'(TURN_CYCLES);

    state_t     state_q, state_d;
    logic [3:0] pkt_cnt_q, pkt_cnt_d;
    logic [2:0] turn_q, turn_d;
    logic       req_q, ack_q, dir_q;
    logic       req_d, ack_d, dir_d;
    logic       gnt;
    logic       pkt_done;

    // Next-state, grant and packet/turnaround counter logic.
    always_comb begin
        state_d   = state_q;
        pkt_cnt_d = pkt_cnt_q;
        turn_d    = turn_q;
        gnt       = 1'b0;
        pkt_done  = 1'b0;
        case (state_q)
            OWN_IDLE: begin
                if (chReqIn && (!localReq || pkt_cnt_q >= MAX_CNT)) begin
                    state_d = RELEASE;
                end else begin
                    gnt = localReq & ~dnStrFull;
                    if (gnt) begin
                        if (localTail) pkt_done = 1'b1;
                        else           state_d  = OWN_XFER;
                    end
                end
            end
            OWN_XFER: begin
                gnt = localReq & ~dnStrFull;
                if (gnt && localTail) begin
                    pkt_done = 1'b1;
                    state_d  = OWN_IDLE;
                end
            end
            RELEASE: state_d = NOT_OWN;
            NOT_OWN: begin
                if (localReq) state_d = REQ;
            end
            REQ: begin
                if (chAckIn) begin
                    state_d   = TURN;
                    turn_d    = TURN_LD;
                    pkt_cnt_d = '0;
                end
            end
            TURN: begin
                if (turn_q <= 3'd1) state_d = OWN_IDLE;
                turn_d = (turn_q != 3'd0) ? turn_q - 3'd1 : '0;
            end
            default: state_d = RST_STATE;
        endcase
        if (pkt_done && pkt_cnt_q < MAX_CNT) pkt_cnt_d = pkt_cnt_q + 4'd1;
    end

    // Link-facing outputs are decoded from the next state so they are flops.
    always_comb begin
        req_d = (state_d == REQ);
        ack_d = (state_d == RELEASE);
        dir_d = (state_d == OWN_IDLE) || (state_d == OWN_XFER) || (state_d == TURN);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q   <= RST_STATE;
            pkt_cnt_q <= '0;
            turn_q    <= '0;
            req_q     <= 1'b0;
            ack_q     <= 1'b0;
            dir_q     <= RST_DIR;
        end else begin
            state_q   <= state_d;
            pkt_cnt_q <= pkt_cnt_d;
            turn_q    <= turn_d;
            req_q     <= req_d;
            ack_q     <= ack_d;
            dir_q     <= dir_d;
        end
    end

    assign localGnt  = gnt & ~rst;
    assign chReqOut  = req_q;
    assign chAckOut  = ack_q;
    assign dirOut    = dir_q;
    assign pktActive = (state_q == OWN_XFER);

endmodule

// File: tb/tb_binoc_channel_ctrl.sv
// Two cross-connected controllers (A owns after reset, B does not) driven by
// random packet streams; expected outputs of both ends come from a link-level
// reference model and are checked by a separate monitor.
module tb_binoc_channel_ctrl;

    localparam int unsigned MAXP = 4;
    localparam int unsigned TC   = 1;

    logic clk = 1'b0;
    logic rst = 1'b1;
    logic lr_a = 1'b0, lt_a = 1'b0, full_a = 1'b0;
    logic lr_b = 1'b0, lt_b = 1'b0, full_b = 1'b0;
    logic gnt_a, req_a, ack_a, dir_a, act_a;
    logic gnt_b, req_b, ack_b, dir_b, act_b;

    always #5 clk = ~clk;

    binoc_channel_ctrl #(.INIT_OWNER(1), .MAX_PKTS(MAXP), .TURN_CYCLES(TC)) u_a (
        .clk(clk), .rst(rst), .localReq(lr_a), .localTail(lt_a), .dnStrFull(full_a),
        .localGnt(gnt_a), .chReqOut(req_a), .chReqIn(req_b), .chAckOut(ack_a),
        .chAckIn(ack_b), .dirOut(dir_a), .pktActive(act_a)
    );

    binoc_channel_ctrl #(.INIT_OWNER(0), .MAX_PKTS(MAXP), .TURN_CYCLES(TC)) u_b (
        .clk(clk), .rst(rst), .localReq(lr_b), .localTail(lt_b), .dnStrFull(full_b),
        .localGnt(gnt_b), .chReqOut(req_b), .chReqIn(req_a), .chAckOut(ack_b),
        .chAckIn(ack_a), .dirOut(dir_b), .pktActive(act_b)
    );

    // Expected {gnt, chReqOut, chAckOut, dirOut, pktActive} per end.
    typedef struct packed {
        logic [4:0] a;
        logic [4:0] b;
        int         cyc;
    } exp_t;

    exp_t q[$];
    int   checks = 0;
    int   errors = 0;

    // Reference model: link ownership, request/ack handshake and packet tally.
    bit          own[2], mid[2], rel[2], req[2];
    int unsigned cnt[2], tl[2];
    int unsigned pkt_left[2];

    task automatic model_reset();
        for (int e = 0; e < 2; e++) begin
            own[e] = (e == 0);
            mid[e] = 1'b0;
            rel[e] = 1'b0;
            req[e] = 1'b0;
            cnt[e] = 0;
            tl[e]  = 0;
        end
    endtask

    // One cycle: choose inputs, predict outputs, push, advance the model.
    task automatic step(input int cyc, input int unsigned st_a, input int unsigned len_a,
                        input int unsigned st_b, input int unsigned len_b,
                        input int unsigned full_pct, input int unsigned rel_rst_pct,
                        input int unsigned rnd_rst_pct, input bit force_rst);
        bit lr[2], lt[2], fu[2], g[2], yld[2], rel_p[2];
        bit rst_v;
        int unsigned st[2], ln[2];
        exp_t ex;
        st[0] = st_a; st[1] = st_b; ln[0] = len_a; ln[1] = len_b;
        @(posedge clk);
        #1;
        for (int e = 0; e < 2; e++) begin
            if (pkt_left[e] == 0 && $urandom_range(0, 99) < st[e])
                pkt_left[e] = $urandom_range(1, ln[e]);
            lr[e] = (pkt_left[e] != 0) && ($urandom_range(0, 9) != 0);
            lt[e] = (pkt_left[e] == 1);
            fu[e] = ($urandom_range(0, 99) < full_pct);
        end
        rst_v = force_rst
              || ((rel[0] || rel[1]) && $urandom_range(0, 99) < rel_rst_pct)
              || ($urandom_range(0, 999) < rnd_rst_pct);
        rst = rst_v;
        lr_a = lr[0]; lt_a = lt[0]; full_a = fu[0];
        lr_b = lr[1]; lt_b = lt[1]; full_b = fu[1];

        for (int e = 0; e < 2; e++) begin
            bit busy;
            busy   = own[e] && tl[e] == 0;
            yld[e] = busy && !mid[e] && req[1-e] && (!lr[e] || cnt[e] >= MAXP);
            g[e]   = busy && !yld[e] && lr[e] && !fu[e] && !rst_v;
        end
        ex.a   = {g[0], req[0], rel[0], own[0], mid[0]};
        ex.b   = {g[1], req[1], rel[1], own[1], mid[1]};
        ex.cyc = cyc;
        if (cyc > 0) q.push_back(ex);

        for (int e = 0; e < 2; e++)
            if (g[e] && pkt_left[e] != 0) pkt_left[e]--;

        if (rst_v) begin
            model_reset();
        end else begin
            rel_p = rel;
            for (int e = 0; e < 2; e++) begin
                if (rel_p[e]) begin
                    rel[e] = 1'b0;
                end else if (own[e] && tl[e] > 0) begin
                    tl[e]--;
                end else if (own[e]) begin
                    if (yld[e]) begin
                        own[e] = 1'b0;
                        rel[e] = 1'b1;
                    end else if (g[e]) begin
                        if (lt[e]) begin
                            mid[e] = 1'b0;
                            if (cnt[e] < MAXP) cnt[e]++;
                        end else begin
                            mid[e] = 1'b1;
                        end
                    end
                end else if (req[e]) begin
                    if (rel_p[1-e]) begin
                        req[e] = 1'b0;
                        own[e] = 1'b1;
                        tl[e]  = TC;
                        cnt[e] = 0;
                    end
                end else if (lr[e]) begin
                    req[e] = 1'b1;
                end
            end
        end
    endtask

    // Monitor: pops one expectation per cycle and compares both ends.
    always @(negedge clk) begin
        if (q.size() > 0) begin
            exp_t ex;
            logic [4:0] act_av, act_bv;
            ex     = q.pop_front();
            act_av = {gnt_a, req_a, ack_a, dir_a, act_a};
            act_bv = {gnt_b, req_b, ack_b, dir_b, act_b};
            checks++;
            if (act_av !== ex.a) begin
                errors++;
                $display("FAIL endA cyc=%0d {gnt,req,ack,dir,act} got=%b expected=%b",
                         ex.cyc, act_av, ex.a);
            end
            checks++;
            if (act_bv !== ex.b) begin
                errors++;
                $display("FAIL endB cyc=%0d {gnt,req,ack,dir,act} got=%b expected=%b",
                         ex.cyc, act_bv, ex.b);
            end
            checks++;
            if (dir_a === 1'b1 && dir_b === 1'b1) begin
                errors++;
                $display("FAIL both_dir cyc=%0d got=11 expected=not both 1", ex.cyc);
            end
        end
    end

    initial begin
        int cyc;
        cyc = 0;
        pkt_left[0] = 0;
        pkt_left[1] = 0;
        model_reset();
        // Reset with A holding a flit, then a quiet A so B can take the link.
        for (int i = 0; i < 3; i++) begin
            step(cyc, 100, 1, 0, 1, 0, 0, 0, 1'b1);
            cyc++;
        end
        for (int i = 0; i < 40; i++) begin
            step(cyc, 0, 1, (i >= 8) ? 100 : 0, 3, 0, 0, 0, 1'b0);
            cyc++;
        end
        // Starvation: A streams single-flit packets, B keeps asking.
        for (int i = 0; i < 300; i++) begin
            step(cyc, 100, 1, 100, 3, 0, 0, 0, 1'b0);
            cyc++;
        end
        // Long wormhole packets with backpressure.
        for (int i = 0; i < 400; i++) begin
            step(cyc, 60, 5, 60, 5, 30, 0, 0, 1'b0);
            cyc++;
        end
        // Sparse traffic with resets landing on release cycles.
        for (int i = 0; i < 400; i++) begin
            step(cyc, 20, 4, 20, 4, 10, 30, 0, 1'b0);
            cyc++;
        end
        // Mixed random traffic with rare random resets.
        for (int i = 0; i < 2000; i++) begin
            step(cyc, $urandom_range(0, 100), $urandom_range(1, 6),
                 $urandom_range(0, 100), $urandom_range(1, 6), 20, 10, 5, 1'b0);
            cyc++;
        end
        @(posedge clk);
        @(posedge clk);
        checks++;
        if (q.size() != 0) begin
            errors++;
            $display("FAIL drain got=%0d pending expected=0", q.size());
        end
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
